tli4970_measurement_scheduler: RTL and testbench
================================================

# tli4970_measurement_scheduler

Sequencer between the PWM timing generator and the multi-channel TLI4970 SPI interface. Issues one measurement trigger per N-th PWM sync pulse and supervises completion with a timeout. Validates the returned per-phase raw frames and publishes checked, sign-extended currents to the current controller. Records overruns, timeouts and sensor status/parity faults.

## Interface

- NumberOfPhases, 3: number of sensor channels/frames handled.
- DecimationWidth, 4: width of the sync decimation count.
- TimeoutCycles, 2048: Clk_ik cycles allowed from trigger to Done_i.
- Clk_ik  in  1  system clock; single clock domain.
- Reset_i  in  1  synchronous, active-high reset.
- Enable_i  in  1  level; 0 stops new triggers (an in-flight measurement still completes).
- SyncPulse_i  in  1  one-cycle PWM centre pulse.
- Decimation_ib  in  DecimationWidth  trigger on every (Decimation_ib+1)-th sync; sampled at each sync.
- TriggerMeasurement_o  out  1  one-cycle start pulse to the SPI interface.
- Done_i  in  1  one-cycle pulse from the SPI interface: frames valid.
- Frames_ib  in  16*NumberOfPhases  raw frames; phase k at bits [16k+15:16k]; valid in the Done_i cycle.
- Currents_ob  out  14*NumberOfPhases  last valid current per phase, sign-extended.
- CurrentsValid_o  out  1  one-cycle pulse when Currents_ob updated.
- FaultMask_ob  out  NumberOfPhases  per-phase fault from the latest completed measurement.
- Timeout_o  out  1  sticky; cleared by reset only.
- OverrunCount_ob8  out  8  saturating count of syncs that hit a busy scheduler.
- Busy_o  out  1  high from trigger until evaluation completes.

## Operation

- States: IDLE, TRIGGER, WAIT, EVALUATE.
- IDLE
  - On SyncPulse_i with Enable_i=1: if the decimation counter equals Decimation_ib, clear it and go to TRIGGER; otherwise increment it.
  - Syncs with Enable_i=0 do not advance the counter.
- TRIGGER: TriggerMeasurement_o=1 for exactly this cycle; load the timeout counter with TimeoutCycles-1; go to WAIT.
- WAIT
  - Done_i=1: register Frames_ib, go to EVALUATE.
  - Counter reaches 0 without Done_i: set Timeout_o; set all FaultMask_ob bits; no current update; no CurrentsValid_o; go to IDLE.
  - Done_i in the same cycle the counter reaches 0 counts as Done; no timeout.
- EVALUATE (1 cycle), per phase k:
  - Frame is valid if bit15=0 (current frame) and the XOR of bits[15:0]=1 (odd parity).
  - Valid frame: Currents_ob[k] <= {frame[12], frame[12:0]}, FaultMask_ob[k] <= 0.
  - Invalid frame (status frame or parity error): current held, FaultMask_ob[k] <= 1.
  - CurrentsValid_o pulses if at least one phase is valid.
  - Then go to IDLE.
- Overrun: a SyncPulse_i while in TRIGGER, WAIT or EVALUATE increments OverrunCount_ob8 (saturates at 255) and is otherwise ignored; the decimation counter is not advanced.
- Done_i outside WAIT is ignored.
- Enable_i dropping mid-measurement has no effect until return to IDLE.
- Reset values: state IDLE, all outputs 0, Currents_ob 0, decimation counter 0. Reset mid-measurement aborts with no pulses in the following cycle.

## Timing

- SyncPulse_i accepted at cycle n -> TriggerMeasurement_o high at n+1.
- Done_i at cycle d -> Currents_ob/FaultMask_ob/CurrentsValid_o updated and visible at d+2 (frames registered at d+1, evaluated at d+1, outputs registered).
- Timeout: with trigger at cycle t, Timeout_o is high at t+TimeoutCycles+1 when no Done_i arrives.
- Busy_o = (state != IDLE), registered with the state.
- A sync at the first IDLE cycle after EVALUATE or timeout is accepted.

## Structure

- Package tli4970_pkg
  - State enum.
  - Frame constants: StatusBit=15, CurrentMsb=12, FrameWidth=16, CurrentOutWidth=14.
  - Function returning frame validity (bit15, parity).
- Sub-module tli4970_frame_checker: one instance per phase via generate. Registered: validity, sign-extended current, fault bit, with load/enable from the FSM.

## Test plan

- Decimation_ib=2, Enable_i=1, syncs every 100 cycles -> triggers on syncs 3, 6, 9; each trigger exactly one cycle after its sync.
- Done_i 40 cycles after trigger, frames 0x0001 (bit15=0, odd parity), 0x1FFF -> Currents 0x0001 and 0x3FFF (-1); FaultMask=000; CurrentsValid_o at Done+2.
- Phase 1 frame 0x8003 (status) and phase 2 frame 0x0003 (even parity) -> FaultMask=110; phases 1 and 2 hold their previous values; CurrentsValid_o pulses.
- No Done_i after trigger, TimeoutCycles=2048 -> Timeout_o high at trigger+2049; FaultMask=111; no CurrentsValid_o; next sync triggers again.
- Syncs every 10 cycles, Done_i after 50 -> OverrunCount increments per extra sync; force 300 overruns -> count stays at 255.
- Reset_i asserted in WAIT with Done_i pending -> all outputs 0 next cycle; a later Done_i is ignored until the next trigger.

Source files
------------

// File: rtl/tli4970_pkg.sv
// Shared types and frame helpers for the TLI4970 measurement scheduler.
// Frames are 16-bit raw sensor words; currents leave as 14-bit signed values.
package tli4970_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TRIGGER,
        WAIT,
        EVALUATE
    } state_e;

    localparam int StatusBit       = 15;
    localparam int CurrentMsb      = 12;
    localparam int FrameWidth      = 16;
    localparam int CurrentOutWidth = 14;

    // Current frame with odd parity across all 16 bits.
    function automatic logic frame_valid(input logic [FrameWidth-1:0] f);
        return !f[StatusBit] && (^f);
    endfunction

endpackage

// File: rtl/tli4970_measurement_scheduler_if.sv
// Trigger/done/frame handshake between the scheduler and the SPI interface.
// master = scheduler side, slave = SPI interface side.
interface tli4970_measurement_scheduler_if #(
    parameter int NumberOfPhases = 3
);
    logic                          TriggerMeasurement_o;
    logic                          Done_i;
    logic [16*NumberOfPhases-1:0]  Frames_ib;

    modport master (
        output TriggerMeasurement_o,
        input  Done_i,
        input  Frames_ib
    );

    modport slave (
        input  TriggerMeasurement_o,
        output Done_i,
        output Frames_ib
    );
endinterface

// File: rtl/tli4970_frame_checker.sv
// Per-phase frame register and validity check; holds the last good current
// and flags status/parity faults or a forced fault after a timeout.
module tli4970_frame_checker
    import tli4970_pkg::*;
(
    input  logic                       Clk_ik,
    input  logic                       Reset_i,
    input  logic                       Load_i,
    input  logic                       Eval_i,
    input  logic                       ForceFault_i,
    input  logic [FrameWidth-1:0]      Frame_ib,
    output logic [CurrentOutWidth-1:0] Current_ob,
    output logic                       Fault_o,
    output logic                       Valid_o
);

    logic [FrameWidth-1:0]      frame_q;
    logic [CurrentOutWidth-1:0] current_q;
    logic                       fault_q;
    logic                       valid_q;
    logic                       ok;

    assign ok = frame_valid(frame_q);

    always_ff @(posedge Clk_ik) begin
        if (Reset_i) begin
            frame_q   <= '0;
            current_q <= '0;
            fault_q   <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (Load_i)
                frame_q <= Frame_ib;
            if (Eval_i) begin
                valid_q <= ok;
                fault_q <= !ok;
                if (ok)
                    current_q <= {frame_q[CurrentMsb], frame_q[CurrentMsb:0]};
            end
            if (ForceFault_i)
                fault_q <= 1'b1;
        end
    end

    assign Current_ob = current_q;
    assign Fault_o    = fault_q;
    assign Valid_o    = valid_q;

endmodule

// File: rtl/tli4970_measurement_scheduler.sv
// Decimated measurement trigger with timeout supervision; publishes checked
// per-phase currents and counts syncs that arrive while busy.
module tli4970_measurement_scheduler
    import tli4970_pkg::*;
#(
    parameter int NumberOfPhases  = 3,
    parameter int DecimationWidth = 4,
    parameter int TimeoutCycles   = 2048
) (
    input  logic                                  Clk_ik,
    input  logic                                  Reset_i,
    input  logic                                  Enable_i,
    input  logic                                  SyncPulse_i,
    input  logic [DecimationWidth-1:0]            Decimation_ib,
    tli4970_measurement_scheduler_if.master       spi_if,
    output logic [CurrentOutWidth*NumberOfPhases-1:0] Currents_ob,
    output logic                                  CurrentsValid_o,
    output logic [NumberOfPhases-1:0]             FaultMask_ob,
    output logic                                  Timeout_o,
    output logic [7:0]                            OverrunCount_ob8,
    output logic                                  Busy_o
);

    localparam int TW = $clog2(TimeoutCycles + 1);

    state_e                     state_q, state_d;
    logic [DecimationWidth-1:0] dec_q, dec_d;
    logic [TW-1:0]              tmr_q, tmr_d;
    logic [7:0]                 ovr_q, ovr_d;
    logic                       timeout_q, timeout_d;
    logic                       trig_q;
    logic                       busy_q;
    logic                       load;
    logic                       eval;
    logic                       force_fault;
    logic [NumberOfPhases-1:0]  valid;

    always_comb begin
        state_d     = state_q;
        dec_d       = dec_q;
        tmr_d       = tmr_q;
        ovr_d       = ovr_q;
        timeout_d   = timeout_q;
        load        = 1'b0;
        eval        = 1'b0;
        force_fault = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (SyncPulse_i && Enable_i) begin
                    if (dec_q == Decimation_ib) begin
                        dec_d   = '0;
                        state_d = TRIGGER;
                    end else begin
                        dec_d = dec_q + DecimationWidth'(1);
                    end
                end
            end
            TRIGGER: begin
                tmr_d   = TW'(TimeoutCycles - 1);
                state_d = WAIT;
            end
            WAIT: begin
                // Done wins over expiry in the final cycle.
                if (spi_if.Done_i) begin
                    load    = 1'b1;
                    state_d = EVALUATE;
                end else if (tmr_q == '0) begin
                    timeout_d   = 1'b1;
                    force_fault = 1'b1;
                    state_d     = IDLE;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            EVALUATE: begin
                eval    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (SyncPulse_i && (state_q != IDLE) && (ovr_q != 8'hFF))
            ovr_d = ovr_q + 8'd1;
    end

    always_ff @(posedge Clk_ik) begin
        if (Reset_i) begin
            state_q   <= IDLE;
            dec_q     <= '0;
            tmr_q     <= '0;
            ovr_q     <= '0;
            timeout_q <= 1'b0;
            trig_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dec_q     <= dec_d;
            tmr_q     <= tmr_d;
            ovr_q     <= ovr_d;
            timeout_q <= timeout_d;
            trig_q    <= (state_d == TRIGGER);
            busy_q    <= (state_d != IDLE);
        end
    end

    for (genvar k = 0; k < NumberOfPhases; k++) begin : g_phase
        tli4970_frame_checker u_chk (
            .Clk_ik      (Clk_ik),
            .Reset_i     (Reset_i),
            .Load_i      (load),
            .Eval_i      (eval),
            .ForceFault_i(force_fault),
            .Frame_ib    (spi_if.Frames_ib[FrameWidth*k +: FrameWidth]),
            .Current_ob  (Currents_ob[CurrentOutWidth*k +: CurrentOutWidth]),
            .Fault_o     (FaultMask_ob[k]),
            .Valid_o     (valid[k])
        );
    end

    assign spi_if.TriggerMeasurement_o = trig_q;
    assign CurrentsValid_o             = |valid;
    assign Timeout_o                   = timeout_q;
    assign OverrunCount_ob8            = ovr_q;
    assign Busy_o                      = busy_q;

endmodule

// File: tb/tb_tli4970_measurement_scheduler.sv
// Directed bench for the measurement scheduler: decimation, evaluation,
// timeout, overrun saturation and reset abort.
module tb_tli4970_measurement_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        sync;
    logic [3:0]  dec;
    logic [41:0] cur;
    logic        cvalid;
    logic [2:0]  fmask;
    logic        tout;
    logic [7:0]  ovr;
    logic        busy;

    int tests = 0;
    int fails = 0;

    tli4970_measurement_scheduler_if #(.NumberOfPhases(3)) spi ();

    tli4970_measurement_scheduler #(
        .NumberOfPhases (3),
        .DecimationWidth(4),
        .TimeoutCycles  (2048)
    ) dut (
        .Clk_ik          (clk),
        .Reset_i         (rst),
        .Enable_i        (en),
        .SyncPulse_i     (sync),
        .Decimation_ib   (dec),
        .spi_if          (spi),
        .Currents_ob     (cur),
        .CurrentsValid_o (cvalid),
        .FaultMask_ob    (fmask),
        .Timeout_o       (tout),
        .OverrunCount_ob8(ovr),
        .Busy_o          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] ph(input int k);
        return cur[14*k +: 14];
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_sync();
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
    endtask

    task automatic pulse_done(input logic [47:0] fr);
        spi.Done_i    = 1'b1;
        spi.Frames_ib = fr;
        @(negedge clk);
        spi.Done_i    = 1'b0;
        spi.Frames_ib = '0;
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b1;
        sync = 1'b0;
        dec  = 4'd2;
        spi.Done_i    = 1'b0;
        spi.Frames_ib = '0;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_trig", spi.TriggerMeasurement_o, 0);
        check("rst_cur", cur, 0);
        check("rst_flags", {cvalid, fmask, tout, busy}, 0);
        check("rst_ovr", ovr, 0);

        // Syncs 1..3 with decimation 2: only the third triggers.
        for (int s = 1; s <= 3; s++) begin
            pulse_sync();
            check($sformatf("dec_trig%0d", s), spi.TriggerMeasurement_o, s == 3);
            if (s < 3) idle(99);
        end
        check("busy_trig", busy, 1);
        @(negedge clk);
        check("trig_one_cycle", spi.TriggerMeasurement_o, 0);
        idle(38);
        pulse_done({16'h0002, 16'h1FFF, 16'h0001});
        check("cv_d1", cvalid, 0);
        @(negedge clk);
        check("cv_d2", cvalid, 1);
        check("cur0_a", ph(0), 14'h0001);
        check("cur1_a", ph(1), 14'h3FFF);
        check("cur2_a", ph(2), 14'h0002);
        check("fm_a", fmask, 3'b000);
        check("busy_end", busy, 0);
        @(negedge clk);
        check("cv_d3", cvalid, 0);

        // Status and even-parity frames on phases 1 and 2.
        for (int s = 4; s <= 6; s++) begin
            pulse_sync();
            check($sformatf("dec_trig%0d", s), spi.TriggerMeasurement_o, s == 6);
            if (s < 6) idle(99);
        end
        idle(39);
        pulse_done({16'h0003, 16'h8003, 16'h0004});
        @(negedge clk);
        check("cv_b", cvalid, 1);
        check("fm_b", fmask, 3'b110);
        check("cur0_b", ph(0), 14'h0004);
        check("cur1_b", ph(1), 14'h3FFF);
        check("cur2_b", ph(2), 14'h0002);

        // Timeout: no Done after trigger.
        for (int s = 7; s <= 9; s++) begin
            pulse_sync();
            if (s < 9) idle(99);
        end
        check("trig9", spi.TriggerMeasurement_o, 1);
        for (int i = 1; i <= 2049; i++) begin
            @(negedge clk);
            if (i == 2048) check("to_early", tout, 0);
            if (i == 2048) check("cv_to_pre", cvalid, 0);
        end
        check("to_set", tout, 1);
        check("fm_to", fmask, 3'b111);
        check("cv_to", cvalid, 0);
        check("busy_to", busy, 0);
        check("cur0_to", ph(0), 14'h0004);

        // Retrigger right away; overruns every 10 cycles, Done after 50.
        dec = 4'd0;
        pulse_sync();
        check("retrig", spi.TriggerMeasurement_o, 1);
        for (int i = 0; i < 4; i++) begin
            idle(9);
            pulse_sync();
        end
        check("ovr4", ovr, 8'd4);
        idle(9);
        pulse_done({16'h0001, 16'h0001, 16'h0001});
        @(negedge clk);
        check("cv_c", cvalid, 1);
        check("fm_c", fmask, 3'b000);
        check("cur2_c", ph(2), 14'h0001);
        check("to_sticky", tout, 1);

        // Saturation: 300 more overruns inside one WAIT.
        pulse_sync();
        check("trig_sat", spi.TriggerMeasurement_o, 1);
        for (int i = 0; i < 300; i++) begin
            pulse_sync();
            @(negedge clk);
        end
        check("ovr_sat", ovr, 8'd255);
        pulse_done({16'h0001, 16'h0001, 16'h0001});
        idle(2);
        check("ovr_hold", ovr, 8'd255);

        // Enable low blocks triggering.
        en = 1'b0;
        pulse_sync();
        check("en_off_trig", spi.TriggerMeasurement_o, 0);
        check("en_off_busy", busy, 0);
        en = 1'b1;

        // Reset in WAIT with Done pending.
        pulse_sync();
        check("trig_rst", spi.TriggerMeasurement_o, 1);
        idle(5);
        rst = 1'b1;
        spi.Done_i    = 1'b1;
        spi.Frames_ib = {16'h0001, 16'h0001, 16'h0002};
        @(negedge clk);
        rst = 1'b0;
        spi.Done_i    = 1'b0;
        spi.Frames_ib = '0;
        check("ra_cur", cur, 0);
        check("ra_flags", {cvalid, fmask, tout, busy}, 0);
        check("ra_ovr", ovr, 0);
        check("ra_trig", spi.TriggerMeasurement_o, 0);
        @(negedge clk);
        check("ra_cv", cvalid, 0);
        pulse_done({16'h0001, 16'h0001, 16'h0002});
        @(negedge clk);
        check("late_done_cv", cvalid, 0);
        check("late_done_cur", cur, 0);
        check("late_done_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
